tlb_frontend: RTL

- Small fully-associative Sv39 instruction/data TLB sitting directly upstream of the page-table walker (MMU).
- Accepts virtual-address lookups from the pipeline and answers hits locally.
- On a miss, issues one walk request to the walker, waits for walker completion, fills an entry and returns the physical address.
- Bypasses translation (identity map) when satp[63]=0.

---
 rtl/tlb_frontend.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/tlb_frontend.sv
`default_nettype none
// ============================================================================
//  Module   : tlb_frontend
//  Brief    : Fully-associative Sv39 TLB in front of the page-table walker.
//             Hits and bypass are answered locally; misses issue one walk,
//             fill an entry and return the walked physical address.
//  Revision : 1.0 - initial release
// ============================================================================
module tlb_frontend #(
  parameter int ENTRIES = 8,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [63:0] satp,
  input  logic        flush,
  input  logic        req_valid,
  input  logic [63:0] req_vaddr,
  output logic        req_ready,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_paddr,
  output logic        resp_hit,
  output logic        resp_fault,
  output logic        walk_valid,
  output logic [63:0] walk_vaddr,
  input  logic        walk_done,
  input  logic [63:0] walk_paddr
);

  localparam int c_IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int c_CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_ISSUE  = 3'd2,
    S_GUARD  = 3'd3,
    S_WAIT   = 3'd4,
    S_RESP   = 3'd5
  } state_t;

  state_t               r_state;
  logic [63:0]          r_vaddr;
  logic [ENTRIES-1:0]   r_valid;
  logic [26:0]          r_vpn [ENTRIES];
  logic [43:0]          r_ppn [ENTRIES];
  logic [c_IDX_W-1:0]   r_rr_ptr;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 r_flush_seen;
  logic                 r_req_ready;
  logic                 r_resp_valid;
  logic [63:0]          r_resp_paddr;
  logic                 r_resp_hit;
  logic                 r_resp_fault;
  logic                 r_walk_valid;
  logic [63:0]          r_walk_vaddr;

  logic                 w_hit;
  logic [43:0]          w_hit_ppn;
  logic                 w_has_free;
  logic [c_IDX_W-1:0]   w_free_idx;
  logic [c_IDX_W-1:0]   w_victim;
  logic                 w_fill;
  logic                 w_unused;

  // Only the Sv39 part of the walker address and the enable bit of satp matter.
  assign w_unused = ^{satp[62:0], walk_paddr[63:56], walk_paddr[11:0]};

  // Associative compare of the registered VPN against all valid entries.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_ppn = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (r_valid[i] && (r_vpn[i] == r_vaddr[38:12])) begin
        w_hit     = 1'b1;
        w_hit_ppn = r_ppn[i];
      end
    end
  end

  // Victim choice: lowest invalid entry, else the round-robin pointer.
  always_comb begin
    w_has_free = 1'b0;
    w_free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_has_free = 1'b1;
        w_free_idx = c_IDX_W'(i);
      end
    end
  end

  assign w_victim = w_has_free ? w_free_idx : r_rr_ptr;
  // A flush anywhere between ISSUE and capture (including the capture edge) blocks the fill.
  assign w_fill   = (r_state == S_WAIT) && walk_done && !r_flush_seen && !flush;

  // Tag/data storage needs no reset: the valid bits qualify every entry.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_vpn[w_victim] <= r_vaddr[38:12];
      r_ppn[w_victim] <= walk_paddr[55:12];
    end
  end

  // Control FSM with registered outputs, valid bits and replacement pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_vaddr      <= '0;
      r_valid      <= '0;
      r_rr_ptr     <= '0;
      r_cnt        <= '0;
      r_flush_seen <= 1'b0;
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_paddr <= '0;
      r_resp_hit   <= 1'b0;
      r_resp_fault <= 1'b0;
      r_walk_valid <= 1'b0;
      r_walk_vaddr <= '0;
    end else begin
      if (flush) begin
        r_valid <= '0;
      end else if (w_fill) begin
        r_valid[w_victim] <= 1'b1;
      end
      if (w_fill && !w_has_free) begin
        r_rr_ptr <= (r_rr_ptr == c_IDX_W'(ENTRIES - 1)) ? '0 : r_rr_ptr + 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          r_req_ready <= 1'b1;
          if (r_req_ready && req_valid) begin
            r_vaddr     <= req_vaddr;
            r_req_ready <= 1'b0;
            r_state     <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (!satp[63]) begin
            r_resp_paddr <= r_vaddr;
            r_resp_hit   <= 1'b1;
            r_state      <= S_RESP;
          end else if (w_hit) begin
            r_resp_paddr <= {8'b0, w_hit_ppn, r_vaddr[11:0]};
            r_resp_hit   <= 1'b1;
            r_state      <= S_RESP;
          end else begin
            r_walk_valid <= 1'b1;
            r_walk_vaddr <= r_vaddr;
            r_flush_seen <= 1'b0;
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_walk_valid <= 1'b0;
          if (flush) r_flush_seen <= 1'b1;
          r_state <= S_GUARD;
        end
        S_GUARD: begin
          // walk_done may still be high from the previous walk: ignore it here.
          if (flush) r_flush_seen <= 1'b1;
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (flush) r_flush_seen <= 1'b1;
          if (walk_done) begin
            r_resp_paddr <= {8'b0, walk_paddr[55:12], r_vaddr[11:0]};
            r_resp_hit   <= 1'b0;
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
          end else if (r_cnt == c_CNT_W'(TIMEOUT - 1)) begin
            r_resp_paddr <= '0;
            r_resp_hit   <= 1'b0;
            r_resp_fault <= 1'b1;
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP: begin
          // Local answers load the data at the compare edge and raise valid
          // one cycle later, fixing hit/bypass latency at two edges.
          if (!r_resp_valid) begin
            r_resp_valid <= 1'b1;
          end else if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_resp_hit   <= 1'b0;
            r_resp_fault <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_paddr = r_resp_paddr;
  assign resp_hit   = r_resp_hit;
  assign resp_fault = r_resp_fault;
  assign walk_valid = r_walk_valid;
  assign walk_vaddr = r_walk_vaddr;

endmodule
`default_nettype wire
